vector_mem_responder: RTL and testbench
=======================================

Name: vector_mem_responder

Overview:
Memory-side responder for the processor's 128-bit vector load/store traffic. It accepts one vector request through a valid/ready handshake and serialises it into 4 word beats against an internal 32-bit word array. Beat k accesses word base+k. For loads, it assembles the 4 words into a 128-bit response held until acknowledged. It sits between the processor's load/store path and word storage, and replaces per-column sequencing done on the initiator side.

Parameters:
ADDR_W, 8, word address width; array depth = 2**ADDR_W words
WORD_W, 32, word width; vector width = 4*WORD_W (lane count fixed at 4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store vector, 0 = load vector
req_addr  in  ADDR_W  base word address
req_wdata  in  4*WORD_W  store data; lane k = bits [WORD_W*k +: WORD_W]
resp_valid  out  1  response available
resp_ready  in  1  initiator accepts response
resp_write  out  1  echo of the captured req_write
resp_rdata  out  4*WORD_W  load data; all zeros for stores
busy  out  1  high in XFER or RESP
beat_idx  out  2  current beat in XFER; 0 otherwise

Behaviour:
- Reset (synchronous, active-high) drives: state=IDLE, req_ready=1, resp_valid=0, resp_write=0, resp_rdata=0, busy=0, beat_idx=0.
- Reset does not clear the word array. Array contents are undefined after power-up.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at a rising edge, capture addr, wdata and write; clear resp_rdata; go to XFER with beat=0.
- XFER:
  - req_ready=0. One beat per cycle, beats 0..3.
  - Store beat k: mem[(addr+k) mod 2**ADDR_W] <= wdata lane k at the edge.
  - Load beat k: resp_rdata lane k <= mem[(addr+k) mod 2**ADDR_W] at the edge. The array read is combinational.
  - After beat 3, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_write stay stable.
  - When resp_ready=1, go to IDLE at that edge and drop resp_valid.
  - A new request is accepted only from IDLE. There is no same-cycle turnaround.
- Latency:
  - Request accepted at edge E0; beats occur at E1..E4; resp_valid rises at E4.
  - Minimum 6 cycles per request: accept, 4 beats, response.
- Address wrap: base+k wraps modulo 2**ADDR_W, e.g. base 0xFE → words 0xFE, 0xFF, 0x00, 0x01.
- req_valid while busy: ignored (req_ready=0), and no inputs are captured. The initiator holds its request until req_ready.
- Inputs are captured once. Changes to req_* inputs during XFER have no effect.
- Reset mid-XFER: aborts the transfer. Beats already written stay in the array. No response is produced, and outputs return to reset values.
- Reset in RESP: the pending response is discarded.
- A load issued immediately after a store to the same words returns the newly stored data.

Optional Feature:
Macro VMEM_LANE_MASK_EN.
- Defined:
  - Adds input port req_mask [3:0], captured with the request.
  - Store: lane k is written only if mask[k]=1.
  - Load: lane k with mask[k]=0 returns zero and performs no array read.
  - Beat timing is unchanged: always 4 beats.
- Undefined: the port is absent and all 4 lanes are always active.

Test Plan:
- Store at base 0x10 with wdata {0xDDDDDDDD, 0xCCCCCCCC, 0xBBBBBBBB, 0xAAAAAAAA}, then load at base 0x10 → resp_rdata equals the same 128-bit value and resp_write=0. resp_valid rises 4 edges after each accept.
- Store at base 0xFE with lanes 1, 2, 3, 4, then load at base 0x00 → lanes 0..1 = 3, 4; lanes 2..3 hold prior contents of words 0x02..0x03 (wrap check).
- Load with resp_ready held low 3 cycles after resp_valid → resp_valid and resp_rdata stable for all 3 cycles. FSM returns to IDLE on the edge where resp_ready=1.
- req_valid pulsed with different addr/data during XFER and RESP → req_ready=0, no capture, array unchanged except the original request's words.
- Reset asserted after beat 1 of a store to base 0x20 → outputs at reset values next cycle. A subsequent load of 0x20 returns lanes 0..1 new and lanes 2..3 old.
- (VMEM_LANE_MASK_EN) Store with mask 4'b0101 over known data, then load with mask 4'b1111 → only lanes 0 and 2 updated. Load with mask 4'b0011 → lanes 2..3 read zero.

Source files
------------

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: serialises one 128-bit vector load/store into four word beats against
// an internal word array. Defining VMEM_LANE_MASK_EN adds a per-lane mask (req_mask).
module vector_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [4*WORD_W-1:0] req_wdata,
`ifdef VMEM_LANE_MASK_EN
  input  logic [3:0]          req_mask,
`endif
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_write,
  output logic [4*WORD_W-1:0] resp_rdata,
  output logic                busy,
  output logic [1:0]          beat_idx
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] base_q;
  logic [WORD_W-1:0] lane_q [4];
  logic              write_q;
  logic [3:0]        mask_q;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] word_addr;
  logic              accept;
  logic              lane_on;
  logic              mem_we;
  logic [WORD_W-1:0] rd_word;

  assign accept    = (state == IDLE) && req_valid;
  // Address arithmetic is ADDR_W bits wide, so base+beat wraps around the array.
  assign word_addr = base_q + ADDR_W'(beat);
  assign lane_on   = mask_q[beat];
  // A beat coinciding with reset is dropped so an aborted store stops at the last full beat.
  assign mem_we    = (state == XFER) && write_q && lane_on && !reset;
  assign rd_word   = lane_on ? mem[word_addr] : '0;
  assign beat_idx  = beat;

  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= req_addr;
      write_q <= req_write;
      for (int k = 0; k < 4; k++) lane_q[k] <= req_wdata[WORD_W*k +: WORD_W];
    end
  end

`ifdef VMEM_LANE_MASK_EN
  always_ff @(posedge clk) begin
    if (accept) mask_q <= req_mask;
  end
`else
  assign mask_q = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_addr] <= lane_q[beat];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      busy       <= 1'b0;
      beat       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= XFER;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            beat       <= 2'd0;
            resp_rdata <= '0;
            resp_write <= req_write;
          end
        end
        XFER: begin
          if (!write_q) resp_rdata[WORD_W*beat +: WORD_W] <= rd_word;
          if (beat == 2'd3) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            beat       <= 2'd0;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_mem_responder.sv
// Scoreboard testbench for vector_mem_responder; define VMEM_LANE_MASK_EN to cover the lane mask.
module tb_vector_mem_responder;
  localparam int AW = 8;
  localparam int WW = 32;
  localparam int VW = 4*WW;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [VW-1:0] req_wdata, resp_rdata;
  logic [3:0]    req_mask;
  logic          resp_valid, resp_ready, resp_write, busy;
  logic [1:0]    beat_idx;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [VW-1:0] rdata;
    logic          wr;
  } exp_t;
  exp_t          exp_q[$];
  logic [WW-1:0] mdl [256];

  always #5 clk = ~clk;

  vector_mem_responder #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef VMEM_LANE_MASK_EN
    .req_mask(req_mask),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .busy(busy), .beat_idx(beat_idx)
  );

  // Reference model: updates mdl for stores, returns the expected response.
  function automatic exp_t predict(logic w, logic [AW-1:0] a, logic [VW-1:0] d, logic [3:0] m);
    exp_t e;
    logic [AW-1:0] wa;
    e.rdata = '0;
    e.wr = w;
    for (int k = 0; k < 4; k++) begin
      wa = a + AW'(k);
      if (m[k]) begin
        if (w) mdl[wa] = d[WW*k +: WW];
        else   e.rdata[WW*k +: WW] = mdl[wa];
      end
    end
    return e;
  endfunction

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [VW-1:0] d,
                        input logic [3:0] m, output logic [VW-1:0] rd, output logic wr,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_mask = m;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_mask = ~m;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = resp_rdata;
    wr = resp_write;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = 4'hF;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_write !== 1'b0) begin bad++; $display("FAIL reset_resp_write got=%b want=0", resp_write); end
    total++; if (resp_rdata !== '0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (beat_idx !== 2'd0) begin bad++; $display("FAIL reset_beat_idx got=%0d want=0", beat_idx); end
    reset = 1'b0;
  endtask

  // Runs a table of transactions through the scoreboard with full response checks.
  task automatic test_table(input string name, input int cnt, input logic w_t[8],
                            input logic [AW-1:0] a_t[8], input logic [VW-1:0] d_t[8],
                            input logic [3:0] m_t[8]);
    logic [VW-1:0] rd;
    logic wr;
    int lat;
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(predict(w_t[i], a_t[i], d_t[i], m_t[i]));
      do_req(w_t[i], a_t[i], d_t[i], m_t[i], rd, wr, lat);
      e = exp_q.pop_front();
      total++; if (rd !== e.rdata) begin bad++; $display("FAIL %s[%0d]_rdata got=%h want=%h", name, i, rd, e.rdata); end
      total++; if (wr !== e.wr) begin bad++; $display("FAIL %s[%0d]_write got=%b want=%b", name, i, wr, e.wr); end
      total++; if (lat !== 4) begin bad++; $display("FAIL %s[%0d]_latency got=%0d want=4", name, i, lat); end
      finish_resp();
    end
  endtask

  task automatic test_store_load();
    logic w_t[8]; logic [AW-1:0] a_t[8]; logic [VW-1:0] d_t[8]; logic [3:0] m_t[8];
    w_t[0] = 1'b1; a_t[0] = 8'h10; d_t[0] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}; m_t[0] = 4'hF;
    w_t[1] = 1'b0; a_t[1] = 8'h10; d_t[1] = {4{32'h12345678}}; m_t[1] = 4'hF;
    test_table("store_load", 2, w_t, a_t, d_t, m_t);
  endtask

  task automatic test_wrap();
    logic w_t[8]; logic [AW-1:0] a_t[8]; logic [VW-1:0] d_t[8]; logic [3:0] m_t[8];
    w_t[0] = 1'b1; a_t[0] = 8'h00; d_t[0] = {32'h0303_0303, 32'h0202_0202, 32'h0101_0101, 32'h0000_0000}; m_t[0] = 4'hF;
    w_t[1] = 1'b1; a_t[1] = 8'hFE; d_t[1] = {32'd4, 32'd3, 32'd2, 32'd1}; m_t[1] = 4'hF;
    w_t[2] = 1'b0; a_t[2] = 8'h00; d_t[2] = '0; m_t[2] = 4'hF;
    w_t[3] = 1'b0; a_t[3] = 8'hFE; d_t[3] = '0; m_t[3] = 4'hF;
    test_table("wrap", 4, w_t, a_t, d_t, m_t);
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] rd;
    logic wr;
    int lat;
    exp_t e;
    exp_q.push_back(predict(1'b0, 8'h10, '0, 4'hF));
    do_req(1'b0, 8'h10, '0, 4'hF, rd, wr, lat);
    e = exp_q.pop_front();
    total++; if (rd !== e.rdata) begin bad++; $display("FAIL bp_rdata got=%h want=%h", rd, e.rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d_valid got=%b want=1", i, resp_valid); end
      total++; if (resp_rdata !== e.rdata) begin bad++; $display("FAIL bp_hold%0d_rdata got=%h want=%h", i, resp_rdata, e.rdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_req_ready got=%b want=0", i, req_ready); end
    end
    finish_resp();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_req_ready got=%b want=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_ignore_busy();
    logic w_t[8]; logic [AW-1:0] a_t[8]; logic [VW-1:0] d_t[8]; logic [3:0] m_t[8];
    exp_t e;
    w_t[0] = 1'b1; a_t[0] = 8'h48; d_t[0] = {32'h4B4B4B4B, 32'h4A4A4A4A, 32'h49494949, 32'h48484848}; m_t[0] = 4'hF;
    test_table("ib_pre", 1, w_t, a_t, d_t, m_t);
    exp_q.push_back(predict(1'b1, 8'h40, {32'h4343, 32'h4242, 32'h4141, 32'h4040}, 4'hF));
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_mask = 4'hF;
    req_wdata = {32'h4343, 32'h4242, 32'h4141, 32'h4040};
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = i[0]; req_addr = 8'h48; req_wdata = {4{$urandom}};
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ib_cyc%0d_req_ready got=%b want=0", i, req_ready); end
      if (i < 4) begin
        total++; if (beat_idx !== 2'(i)) begin bad++; $display("FAIL ib_cyc%0d_beat_idx got=%0d want=%0d", i, beat_idx, i); end
      end else begin
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL ib_cyc%0d_resp_valid got=%b want=1", i, resp_valid); end
      end
      if (i < 5) @(negedge clk);
    end
    e = exp_q.pop_front();
    total++; if (resp_write !== e.wr) begin bad++; $display("FAIL ib_resp_write got=%b want=%b", resp_write, e.wr); end
    total++; if (resp_rdata !== e.rdata) begin bad++; $display("FAIL ib_resp_rdata got=%h want=%h", resp_rdata, e.rdata); end
    req_valid = 1'b0;
    finish_resp();
    w_t[0] = 1'b0; a_t[0] = 8'h40; d_t[0] = '0; m_t[0] = 4'hF;
    w_t[1] = 1'b0; a_t[1] = 8'h48; d_t[1] = '0; m_t[1] = 4'hF;
    test_table("ib_post", 2, w_t, a_t, d_t, m_t);
  endtask

  task automatic test_reset_mid_xfer();
    logic w_t[8]; logic [AW-1:0] a_t[8]; logic [VW-1:0] d_t[8]; logic [3:0] m_t[8];
    logic [VW-1:0] nd;
    nd = {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000};
    w_t[0] = 1'b1; a_t[0] = 8'h20; d_t[0] = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}; m_t[0] = 4'hF;
    test_table("rm_pre", 1, w_t, a_t, d_t, m_t);
    // Only beats 0 and 1 complete before reset lands.
    mdl[8'h20] = nd[31:0];
    mdl[8'h21] = nd[63:32];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = nd; req_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_req_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_resp_valid got=%b want=0", resp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
    total++; if (beat_idx !== 2'd0) begin bad++; $display("FAIL rm_beat_idx got=%0d want=0", beat_idx); end
    total++; if (resp_write !== 1'b0) begin bad++; $display("FAIL rm_resp_write got=%b want=0", resp_write); end
    w_t[0] = 1'b0; a_t[0] = 8'h20; d_t[0] = '0; m_t[0] = 4'hF;
    test_table("rm_post", 1, w_t, a_t, d_t, m_t);
  endtask

  task automatic test_random();
    logic w_t[8]; logic [AW-1:0] a_t[8]; logic [VW-1:0] d_t[8]; logic [3:0] m_t[8];
    for (int i = 0; i < 4; i++) begin
      a_t[2*i] = AW'($urandom_range(0, 255));
      a_t[2*i+1] = a_t[2*i];
      w_t[2*i] = 1'b1; w_t[2*i+1] = 1'b0;
      d_t[2*i] = {$urandom, $urandom, $urandom, $urandom}; d_t[2*i+1] = '0;
      m_t[2*i] = 4'hF; m_t[2*i+1] = 4'hF;
    end
    test_table("random", 8, w_t, a_t, d_t, m_t);
  endtask

`ifdef VMEM_LANE_MASK_EN
  task automatic test_mask();
    logic w_t[8]; logic [AW-1:0] a_t[8]; logic [VW-1:0] d_t[8]; logic [3:0] m_t[8];
    w_t[0] = 1'b1; a_t[0] = 8'h60; d_t[0] = {4{32'h5555AAAA}}; m_t[0] = 4'hF;
    w_t[1] = 1'b1; a_t[1] = 8'h60; d_t[1] = {32'h33, 32'h22, 32'h11, 32'h00}; m_t[1] = 4'b0101;
    w_t[2] = 1'b0; a_t[2] = 8'h60; d_t[2] = '0; m_t[2] = 4'hF;
    w_t[3] = 1'b0; a_t[3] = 8'h60; d_t[3] = '0; m_t[3] = 4'b0011;
    test_table("mask", 4, w_t, a_t, d_t, m_t);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid_xfer();
    test_random();
`ifdef VMEM_LANE_MASK_EN
    test_mask();
`endif
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
